// File: rtl/cdb_writeback.sv
// ---------------------------------------------------------------------------
// cdb_writeback
//
// Common data bus writeback stage. Three execution units (adder, multiplier,
// load) each hand results to a private one-entry holding register. Every
// cycle a round-robin arbiter picks one occupied holding register. On the
// next rising edge the winner's result goes out on the CDB for exactly one
// cycle. A granted holding register may be refilled on the same edge that
// empties it, so one source streaming alone still gets one broadcast per
// cycle.
//
// Parameters
//   DATA_W  result data width
//   TAG_W   reservation-station tag width (tag 0 = "no producer")
//   ROB_W   ROB slot index width
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset (takes priority over flush)
//   flush        synchronous discard of all held and outgoing results
//   src_valid    per-source result valid (bit 0 adder, 1 mult, 2 load)
//   src_data     per-source result, source s at [s*DATA_W +: DATA_W]
//   src_tag      per-source producer tag, packed like src_data
//   src_rob      per-source ROB slot, packed like src_data
//   src_ready    per-source acceptance (transfer = valid & ready at an edge)
//   cdb_valid    broadcast valid, one cycle per broadcast
//   cdb_data     broadcast result
//   cdb_tag      broadcast producer tag
//   cdb_rob      broadcast ROB slot
//   cdb_src      winning source index
//   bcast_count  broadcasts since reset, wraps at 16 bits
// ---------------------------------------------------------------------------
module cdb_writeback #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4,
    parameter int ROB_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [2:0]            src_valid,
    input  logic [3*DATA_W-1:0]   src_data,
    input  logic [3*TAG_W-1:0]    src_tag,
    input  logic [3*ROB_W-1:0]    src_rob,
    output logic [2:0]            src_ready,
    output logic                  cdb_valid,
    output logic [DATA_W-1:0]     cdb_data,
    output logic [TAG_W-1:0]      cdb_tag,
    output logic [ROB_W-1:0]      cdb_rob,
    output logic [1:0]            cdb_src,
    output logic [15:0]           bcast_count
);

    // Holding registers, one per source
    logic [2:0]        hold_valid;
    logic [DATA_W-1:0] hold_data [3];
    logic [TAG_W-1:0]  hold_tag  [3];
    logic [ROB_W-1:0]  hold_rob  [3];

    // Round-robin pointer: the source searched first this cycle
    logic [1:0] rr_ptr;

    // Arbitration results
    logic [2:0]        grant;
    logic [1:0]        win_idx;
    logic              win_found;
    logic [1:0]        cand;
    logic [3:0]        hv_ext;
    logic [DATA_W-1:0] win_data;
    logic [TAG_W-1:0]  win_tag;
    logic [ROB_W-1:0]  win_rob;

    // Successor in the 0 -> 1 -> 2 -> 0 ring. The unused code 3 maps to 0.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Round-robin search over occupied holding registers, starting at
    // rr_ptr. hold_valid is widened to 4 bits so the 2-bit candidate index
    // can never land outside the vector. No grant is issued during reset or
    // flush, because those cycles must not consume any pending result.
    always_comb begin
        grant     = 3'b000;
        win_idx   = 2'd0;
        win_found = 1'b0;
        hv_ext    = {1'b0, hold_valid};
        cand      = (rr_ptr == 2'd3) ? 2'd0 : rr_ptr;
        for (int i = 0; i < 3; i++) begin
            if (!win_found && hv_ext[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
            cand = next_idx(cand);
        end
        if (win_found && !rst && !flush) begin
            grant = 3'b001 << win_idx;
        end
    end

    // Route the winning entry to the broadcast registers
    always_comb begin
        win_data = hold_data[0];
        win_tag  = hold_tag[0];
        win_rob  = hold_rob[0];
        case (win_idx)
            2'd1: begin
                win_data = hold_data[1];
                win_tag  = hold_tag[1];
                win_rob  = hold_rob[1];
            end
            2'd2: begin
                win_data = hold_data[2];
                win_tag  = hold_tag[2];
                win_rob  = hold_rob[2];
            end
            default: begin
                win_data = hold_data[0];
                win_tag  = hold_tag[0];
                win_rob  = hold_rob[0];
            end
        endcase
    end

    // An entry being granted this cycle frees up at the same edge, so it
    // can take a new result immediately.
    assign src_ready = {3{~rst & ~flush}} & (~hold_valid | grant);

    // Holding registers, broadcast registers, pointer and counter.
    // A tag-0 result is accepted but discarded: the entry stays empty.
    // Holding payloads need no reset because hold_valid qualifies them.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid  <= 3'b000;
            rr_ptr      <= 2'd0;
            cdb_valid   <= 1'b0;
            cdb_data    <= '0;
            cdb_tag     <= '0;
            cdb_rob     <= '0;
            cdb_src     <= 2'd0;
            bcast_count <= 16'd0;
        end else if (flush) begin
            hold_valid <= 3'b000;
            cdb_valid  <= 1'b0;
        end else begin
            for (int s = 0; s < 3; s++) begin
                if (src_valid[s] && src_ready[s]) begin
                    hold_valid[s] <= (src_tag[s*TAG_W +: TAG_W] != '0);
                    hold_data[s]  <= src_data[s*DATA_W +: DATA_W];
                    hold_tag[s]   <= src_tag[s*TAG_W +: TAG_W];
                    hold_rob[s]   <= src_rob[s*ROB_W +: ROB_W];
                end else if (grant[s]) begin
                    hold_valid[s] <= 1'b0;
                end
            end

            if (|grant) begin
                cdb_valid   <= 1'b1;
                cdb_data    <= win_data;
                cdb_tag     <= win_tag;
                cdb_rob     <= win_rob;
                cdb_src     <= win_idx;
                rr_ptr      <= next_idx(win_idx);
                bcast_count <= bcast_count + 16'd1;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_writeback.sv
// ---------------------------------------------------------------------------
// tb_cdb_writeback
//
// Self-checking bench for cdb_writeback. A behavioural model tracks what
// each source has pending, which source is next in line, and what the bus
// must show. It is compared against every DUT output on every cycle.
// Directed scenarios add literal expectations, and a long randomized phase
// with occasional flush/reset exercises interleavings.
// ---------------------------------------------------------------------------
module tb_cdb_writeback;

    localparam int DATA_W = 64;
    localparam int TAG_W  = 4;
    localparam int ROB_W  = 2;

    logic                clk;
    logic                rst;
    logic                flush;
    logic [2:0]          src_valid;
    logic [3*DATA_W-1:0] src_data;
    logic [3*TAG_W-1:0]  src_tag;
    logic [3*ROB_W-1:0]  src_rob;
    logic [2:0]          src_ready;
    logic                cdb_valid;
    logic [DATA_W-1:0]   cdb_data;
    logic [TAG_W-1:0]    cdb_tag;
    logic [ROB_W-1:0]    cdb_rob;
    logic [1:0]          cdb_src;
    logic [15:0]         bcast_count;

    int total_checks = 0;
    int bad_checks   = 0;

    cdb_writeback #(.DATA_W(DATA_W), .TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_tag     (src_tag),
        .src_rob     (src_rob),
        .src_ready   (src_ready),
        .cdb_valid   (cdb_valid),
        .cdb_data    (cdb_data),
        .cdb_tag     (cdb_tag),
        .cdb_rob     (cdb_rob),
        .cdb_src     (cdb_src),
        .bcast_count (bcast_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: what each source is waiting to broadcast and who is next
    bit          m_pend [3];
    logic [63:0] m_data [3];
    logic [3:0]  m_tag  [3];
    logic [1:0]  m_rob  [3];
    int          m_next;
    logic        m_cv;
    logic [63:0] m_cd;
    logic [3:0]  m_ct;
    logic [1:0]  m_cr;
    logic [1:0]  m_cs;
    int          m_cnt;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_checks++;
        if (act !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // First pending source going round from m_next, or -1 if none
    function automatic int modelWinner();
        for (int i = 0; i < 3; i++) begin
            int c;
            c = (m_next + i) % 3;
            if (m_pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int s = 0; s < 3; s++) m_pend[s] = 1'b0;
        m_next = 0;
        m_cv   = 1'b0;
        m_cd   = '0;
        m_ct   = '0;
        m_cr   = '0;
        m_cs   = '0;
        m_cnt  = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at it
    task automatic modelEdge();
        int w;
        if (rst) begin
            modelReset();
        end else if (flush) begin
            for (int s = 0; s < 3; s++) m_pend[s] = 1'b0;
            m_cv = 1'b0;
        end else begin
            w = modelWinner();
            if (w >= 0) begin
                m_cv     = 1'b1;
                m_cd     = m_data[w];
                m_ct     = m_tag[w];
                m_cr     = m_rob[w];
                m_cs     = w[1:0];
                m_cnt    = (m_cnt + 1) % 65536;
                m_next   = (w + 1) % 3;
                m_pend[w] = 1'b0;
            end else begin
                m_cv = 1'b0;
            end
            for (int s = 0; s < 3; s++) begin
                if (src_valid[s] && !m_pend[s]) begin
                    m_pend[s] = (src_tag[s*TAG_W +: TAG_W] != 4'd0);
                    m_data[s] = src_data[s*DATA_W +: DATA_W];
                    m_tag[s]  = src_tag[s*TAG_W +: TAG_W];
                    m_rob[s]  = src_rob[s*ROB_W +: ROB_W];
                end
            end
        end
    endtask

    // Compare registered outputs against the model
    task automatic checkOutput();
        checkVal("cdb_valid", {63'd0, cdb_valid}, {63'd0, m_cv});
        checkVal("bcast_count", {48'd0, bcast_count}, 64'(m_cnt));
        if (m_cv) begin
            checkVal("cdb_data", cdb_data, m_cd);
            checkVal("cdb_tag", {60'd0, cdb_tag}, {60'd0, m_ct});
            checkVal("cdb_rob", {62'd0, cdb_rob}, {62'd0, m_cr});
            checkVal("cdb_src", {62'd0, cdb_src}, {62'd0, m_cs});
        end
    endtask

    // One clock cycle: check combinational ready, clock, check registers
    task automatic step();
        int   w;
        logic [2:0] exp_ready;
        #1;
        w = modelWinner();
        for (int s = 0; s < 3; s++)
            exp_ready[s] = !rst && !flush && (!m_pend[s] || (w == s));
        checkVal("src_ready", {61'd0, src_ready}, {61'd0, exp_ready});
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic clearInputs();
        src_valid = 3'b000;
        src_data  = '0;
        src_tag   = '0;
        src_rob   = '0;
        flush     = 1'b0;
    endtask

    task automatic setSrc(input int s, input logic [63:0] d, input logic [3:0] t, input logic [1:0] r);
        src_valid[s]              = 1'b1;
        src_data[s*DATA_W +: DATA_W] = d;
        src_tag[s*TAG_W +: TAG_W]    = t;
        src_rob[s*ROB_W +: ROB_W]    = r;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        checkVal("ready after reset", {61'd0, src_ready}, 64'h7);
    endtask

    // Random inputs for one cycle, with rare flush and reset
    task automatic applyStimulus();
        for (int s = 0; s < 3; s++) begin
            src_valid[s]                 = ($urandom_range(0, 9) < 6);
            src_data[s*DATA_W +: DATA_W] = {$urandom, $urandom};
            src_tag[s*TAG_W +: TAG_W]    = 4'($urandom_range(0, 15));
            src_rob[s*ROB_W +: ROB_W]    = 2'($urandom_range(0, 3));
        end
        flush = ($urandom_range(0, 19) == 0);
        rst   = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        rst = 1'b1;
        clearInputs();
        modelReset();
        @(negedge clk);

        // Single adder result
        doReset();
        setSrc(0, 64'h1234, 4'd3, 2'd1);
        step();
        clearInputs();
        checkVal("single not early", {63'd0, cdb_valid}, 64'd0);
        step();
        checkVal("single valid", {63'd0, cdb_valid}, 64'd1);
        checkVal("single data", cdb_data, 64'h1234);
        checkVal("single tag", {60'd0, cdb_tag}, 64'd3);
        checkVal("single rob", {62'd0, cdb_rob}, 64'd1);
        checkVal("single src", {62'd0, cdb_src}, 64'd0);
        checkVal("single count", {48'd0, bcast_count}, 64'd1);
        step();
        checkVal("single one-shot", {63'd0, cdb_valid}, 64'd0);

        // All three at once: adder, mult, load, then pointer back at adder
        doReset();
        setSrc(0, 64'hA0, 4'd1, 2'd0);
        setSrc(1, 64'hB1, 4'd2, 2'd1);
        setSrc(2, 64'hC2, 4'd5, 2'd2);
        step();
        clearInputs();
        step();
        checkVal("rr first src", {62'd0, cdb_src}, 64'd0);
        checkVal("rr first data", cdb_data, 64'hA0);
        step();
        checkVal("rr second src", {62'd0, cdb_src}, 64'd1);
        checkVal("rr second data", cdb_data, 64'hB1);
        step();
        checkVal("rr third src", {62'd0, cdb_src}, 64'd2);
        checkVal("rr third data", cdb_data, 64'hC2);
        step();
        checkVal("rr idle", {63'd0, cdb_valid}, 64'd0);
        setSrc(1, 64'hD1, 4'd7, 2'd3);
        setSrc(0, 64'hD0, 4'd6, 2'd2);
        step();
        clearInputs();
        step();
        checkVal("rr ptr wrapped", {62'd0, cdb_src}, 64'd0);
        step();
        checkVal("rr ptr next", {62'd0, cdb_src}, 64'd1);
        checkVal("rr count", {48'd0, bcast_count}, 64'd5);

        // Tag 0 is accepted and dropped
        doReset();
        setSrc(2, 64'hDEAD, 4'd0, 2'd2);
        #1;
        checkVal("tag0 ready", {63'd0, src_ready[2]}, 64'd1);
        step();
        clearInputs();
        step();
        checkVal("tag0 no bcast", {63'd0, cdb_valid}, 64'd0);
        step();
        checkVal("tag0 no bcast later", {63'd0, cdb_valid}, 64'd0);
        checkVal("tag0 count", {48'd0, bcast_count}, 64'd0);

        // Flush just before the grant edge discards held results
        doReset();
        setSrc(0, 64'h11, 4'd4, 2'd0);
        setSrc(2, 64'h22, 4'd8, 2'd3);
        step();
        clearInputs();
        flush = 1'b1;
        #1;
        checkVal("flush ready", {61'd0, src_ready}, 64'd0);
        step();
        flush = 1'b0;
        step();
        checkVal("flush no bcast", {63'd0, cdb_valid}, 64'd0);
        step();
        checkVal("flush no bcast later", {63'd0, cdb_valid}, 64'd0);
        checkVal("flush count", {48'd0, bcast_count}, 64'd0);
        setSrc(0, 64'h33, 4'd9, 2'd1);
        step();
        clearInputs();
        step();
        checkVal("post-flush valid", {63'd0, cdb_valid}, 64'd1);
        checkVal("post-flush data", cdb_data, 64'h33);
        checkVal("post-flush count", {48'd0, bcast_count}, 64'd1);

        // Randomized traffic
        doReset();
        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
            step();
        end
        rst = 1'b0;

        // Multiplier streaming until the counter wraps
        doReset();
        for (int k = 0; k < 70000 && m_cnt != 65535; k++) begin
            clearInputs();
            setSrc(1, 64'(k), 4'd2, 2'(k));
            step();
            if (k >= 1 && k <= 5) begin
                checkVal("stream valid", {63'd0, cdb_valid}, 64'd1);
                checkVal("stream src", {62'd0, cdb_src}, 64'd1);
                checkVal("stream data", cdb_data, 64'(k - 1));
            end
        end
        checkVal("count at max", {48'd0, bcast_count}, 64'hFFFF);
        setSrc(1, 64'h5555, 4'd2, 2'd0);
        step();
        checkVal("count wrapped", {48'd0, bcast_count}, 64'h0);
        checkVal("wrap still valid", {63'd0, cdb_valid}, 64'd1);

        // Reset in the middle of the stream
        rst = 1'b1;
        #1;
        checkVal("rst ready", {61'd0, src_ready}, 64'd0);
        step();
        checkVal("rst cdb_valid", {63'd0, cdb_valid}, 64'd0);
        checkVal("rst cdb_data", cdb_data, 64'd0);
        checkVal("rst cdb_tag", {60'd0, cdb_tag}, 64'd0);
        checkVal("rst cdb_rob", {62'd0, cdb_rob}, 64'd0);
        checkVal("rst cdb_src", {62'd0, cdb_src}, 64'd0);
        checkVal("rst count", {48'd0, bcast_count}, 64'd0);
        rst = 1'b0;
        clearInputs();
        step();
        step();
        checkVal("rst nothing pending", {63'd0, cdb_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
